// File: rtl/vx_ahb_sram_subordinate_if.sv
// AHB-Lite bus bundle between the Vortex memory-side manager and the SRAM subordinate.
// The manager drives the address/data-phase signals; the subordinate returns HREADY/HRESP/HRDATA.
interface vx_ahb_sram_subordinate_if;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [3:0]  HWSTRB;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HWSTRB,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HWSTRB,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/vx_ahb_sram_subordinate.sv
// AHB-Lite subordinate backed by a word-addressed SRAM with byte strobes and ERROR responses.
// Define AHB_SUB_WAITSTATE_EN to insert WAIT_CYCLES wait states into every non-error data phase.
module vx_ahb_sram_subordinate #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       nRST,
    vx_ahb_sram_subordinate_if.slave   bus
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    generate
        if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
            $error("DEPTH_WORDS must be a power of two");
        end
        if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_waits
            $error("WAIT_CYCLES must be in 0..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef AHB_SUB_WAITSTATE_EN
        ST_WAIT,
`endif
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state;
    logic            write_q;
    logic [AW-1:0]   idx_q;
    logic            ready_q;
    logic            resp_q;
    logic [31:0]     rdata_q;
`ifdef AHB_SUB_WAITSTATE_EN
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    logic [3:0]      wait_cnt;
`endif

    logic [31:0]     mem [0:DEPTH_WORDS-1];

    logic            accept;
    logic            addr_err;
    logic            commit;
    logic [AW-1:0]   new_idx;
    logic [31:0]     fwd_rdata;
    logic            unused_htrans0;

    assign unused_htrans0 = bus.HTRANS[0];

    assign accept   = bus.HSEL & bus.HTRANS[1] & ready_q;
    assign addr_err = (bus.HSIZE != 3'b010)
                    | (bus.HADDR[1:0] != 2'b00)
                    | (bus.HADDR < BASE_ADDR)
                    | ({1'b0, bus.HADDR} >= END_ADDR);
    assign new_idx  = AW'((bus.HADDR - BASE_ADDR) >> 2);
    assign commit   = (state == ST_DATA) && write_q;

    // A read accepted during a committing write to the same word must see the merged bytes.
    always_comb begin
        fwd_rdata = mem[new_idx];
        if (commit && (idx_q == new_idx)) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.HWSTRB[k]) begin
                    fwd_rdata[8*k +: 8] = bus.HWDATA[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.HWSTRB[k]) begin
                    mem[idx_q][8*k +: 8] <= bus.HWDATA[8*k +: 8];
                end
            end
        end
    end

    // Outputs are registered alongside the state so they change only on clock edges.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b1;
            resp_q   <= 1'b0;
            rdata_q  <= '0;
            write_q  <= 1'b0;
            idx_q    <= '0;
`ifdef AHB_SUB_WAITSTATE_EN
            wait_cnt <= '0;
`endif
        end else begin
            rdata_q <= '0;
            case (state)
`ifdef AHB_SUB_WAITSTATE_EN
                ST_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        state    <= ST_DATA;
                        ready_q  <= 1'b1;
                        resp_q   <= 1'b0;
                        wait_cnt <= '0;
                        if (!write_q) begin
                            rdata_q <= mem[idx_q];
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
`endif
                ST_ERR1: begin
                    state   <= ST_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        write_q <= bus.HWRITE;
                        idx_q   <= new_idx;
                        if (addr_err) begin
                            state   <= ST_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= 1'b1;
                        end
`ifdef AHB_SUB_WAITSTATE_EN
                        else if (WAIT_INIT != 4'd0) begin
                            state    <= ST_WAIT;
                            ready_q  <= 1'b0;
                            resp_q   <= 1'b0;
                            wait_cnt <= WAIT_INIT;
                        end
`endif
                        else begin
                            state   <= ST_DATA;
                            ready_q <= 1'b1;
                            resp_q  <= 1'b0;
                            if (!bus.HWRITE) begin
                                rdata_q <= fwd_rdata;
                            end
                        end
                    end else begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.HREADY = ready_q;
    assign bus.HRESP  = resp_q;
    assign bus.HRDATA = rdata_q;

endmodule

// File: tb/tb_vx_ahb_sram_subordinate.sv
// Directed bench for vx_ahb_sram_subordinate; works with or without AHB_SUB_WAITSTATE_EN.
module tb_vx_ahb_sram_subordinate;

    localparam int WAIT_CYCLES = 2;
`ifdef AHB_SUB_WAITSTATE_EN
    localparam int EXP_WAITS = WAIT_CYCLES;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic clk = 1'b0;
    logic nRST;
    always #5 clk = ~clk;

    vx_ahb_sram_subordinate_if bus ();

    vx_ahb_sram_subordinate #(
        .BASE_ADDR   (32'h0000_0000),
        .DEPTH_WORDS (4096),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int burst_cycles;

    logic [31:0] addr_tbl  [32];
    logic [31:0] wdata_tbl [32];
    logic [31:0] rdata_tbl [32];
    logic        wr_tbl    [32];
    logic [2:0]  size_tbl  [32];
    logic [3:0]  strb_tbl  [32];
    int          stall_tbl [32];
    logic        respf_tbl [32];
    logic        respl_tbl [32];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic setXfer(input int i, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [2:0] size = 3'b010);
        wr_tbl[i]    = wr;
        addr_tbl[i]  = addr;
        wdata_tbl[i] = wdata;
        strb_tbl[i]  = strb;
        size_tbl[i]  = size;
    endtask

    task automatic driveIdle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b010;
        bus.HADDR  = 32'h0;
        bus.HWDATA = 32'h0;
        bus.HWSTRB = 4'h0;
    endtask

    // Pipelined manager: address of transfer i overlaps the data phase of transfer i-1.
    // Called and returns 1 time unit after a rising edge.
    task automatic applyStimulus(input int n);
        int  cyc;
        bit  done;
        burst_cycles = 0;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                bus.HSEL   = 1'b1;
                bus.HTRANS = 2'b10;
                bus.HADDR  = addr_tbl[i];
                bus.HWRITE = wr_tbl[i];
                bus.HSIZE  = size_tbl[i];
            end else begin
                bus.HSEL   = 1'b0;
                bus.HTRANS = 2'b00;
                bus.HADDR  = 32'h0;
                bus.HWRITE = 1'b0;
                bus.HSIZE  = 3'b010;
            end
            if (i > 0) begin
                bus.HWDATA = wdata_tbl[i-1];
                bus.HWSTRB = strb_tbl[i-1];
            end else begin
                bus.HWDATA = 32'h0;
                bus.HWSTRB = 4'h0;
            end
            done = 1'b0;
            for (cyc = 0; cyc < 40 && !done; cyc++) begin
                @(negedge clk);
                if (i > 0) begin
                    if (cyc == 0) respf_tbl[i-1] = bus.HRESP;
                    respl_tbl[i-1] = bus.HRESP;
                    rdata_tbl[i-1] = bus.HRDATA;
                end
                done = bus.HREADY;
                @(posedge clk);
                #1;
                burst_cycles++;
            end
            if (!done) begin
                checkOutput($sformatf("hready_timeout_xfer%0d", i), 32'd0, 32'd1);
                driveIdle();
                return;
            end
            if (i > 0) stall_tbl[i-1] = cyc - 1;
        end
    endtask

    initial begin
        driveIdle();
        nRST = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("in_reset_hready", {31'b0, bus.HREADY}, 32'd1);
        checkOutput("in_reset_hresp",  {31'b0, bus.HRESP},  32'd0);
        @(negedge clk);
        nRST = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("idle%0d_hready", k), {31'b0, bus.HREADY}, 32'd1);
            checkOutput($sformatf("idle%0d_hresp", k),  {31'b0, bus.HRESP},  32'd0);
            checkOutput($sformatf("idle%0d_hrdata", k), bus.HRDATA, 32'h0);
        end
        @(posedge clk);
        #1;

        // Write then read of the same word, back to back
        setXfer(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
        setXfer(1, 1'b0, 32'h40, 32'h0, 4'h0);
        applyStimulus(2);
        checkOutput("wr_rd_hrdata_on_write", rdata_tbl[0], 32'h0);
        checkOutput("wr_rd_read_data", rdata_tbl[1], 32'hDEADBEEF);
        checkOutput("wr_rd_write_stalls", 32'(stall_tbl[0]), 32'(EXP_WAITS));
        checkOutput("wr_rd_read_stalls", 32'(stall_tbl[1]), 32'(EXP_WAITS));
        checkOutput("wr_rd_resp", {31'b0, respl_tbl[1]}, 32'd0);
        checkOutput("wr_rd_cycles", 32'(burst_cycles), 32'(1 + 2 * (1 + EXP_WAITS)));

        // Byte strobes, separate transfers
        setXfer(0, 1'b1, 32'h80, 32'h11223344, 4'hF);
        applyStimulus(1);
        setXfer(0, 1'b1, 32'h80, 32'hAABBCCDD, 4'b0101);
        applyStimulus(1);
        setXfer(0, 1'b0, 32'h80, 32'h0, 4'h0);
        applyStimulus(1);
        checkOutput("strobe_merge", rdata_tbl[0], 32'h11BB33DD);
        checkOutput("single_cycles", 32'(burst_cycles), 32'(2 + EXP_WAITS));

        // Partial write followed immediately by a read of the same word
        setXfer(0, 1'b1, 32'h40, 32'hCAFE0000, 4'b1100);
        setXfer(1, 1'b0, 32'h40, 32'h0, 4'h0);
        applyStimulus(2);
        checkOutput("raw_partial", rdata_tbl[1], 32'hCAFEBEEF);

        // Sixteen-word line: writes then reads
        for (int i = 0; i < 16; i++) setXfer(i, 1'b1, 32'h1000 + 32'(4 * i), 32'(i), 4'hF);
        applyStimulus(16);
        checkOutput("line_wr_cycles", 32'(burst_cycles), 32'(1 + 16 * (1 + EXP_WAITS)));
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("line_wr%0d_stalls", i), 32'(stall_tbl[i]), 32'(EXP_WAITS));
        for (int i = 0; i < 16; i++) setXfer(i, 1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'h0);
        applyStimulus(16);
        checkOutput("line_rd_cycles", 32'(burst_cycles), 32'(1 + 16 * (1 + EXP_WAITS)));
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("line_rd%0d_data", i), rdata_tbl[i], 32'(i));
            checkOutput($sformatf("line_rd%0d_stalls", i), 32'(stall_tbl[i]), 32'(EXP_WAITS));
        end

        // First and last words, then error transfers that must not disturb them
        setXfer(0, 1'b1, 32'h0,    32'h5A5A5A5A, 4'hF);
        setXfer(1, 1'b1, 32'h3FFC, 32'h0BADF00D, 4'hF);
        applyStimulus(2);
        setXfer(0, 1'b0, 32'h4000, 32'h0, 4'h0);
        applyStimulus(1);
        checkOutput("err_oob_stalls", 32'(stall_tbl[0]), 32'd1);
        checkOutput("err_oob_resp_first", {31'b0, respf_tbl[0]}, 32'd1);
        checkOutput("err_oob_resp_last",  {31'b0, respl_tbl[0]}, 32'd1);
        checkOutput("err_oob_hrdata", rdata_tbl[0], 32'h0);
        checkOutput("err_oob_cycles", 32'(burst_cycles), 32'd3);
        setXfer(0, 1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 3'b000);
        applyStimulus(1);
        checkOutput("err_size_stalls", 32'(stall_tbl[0]), 32'd1);
        checkOutput("err_size_resp_first", {31'b0, respf_tbl[0]}, 32'd1);
        checkOutput("err_size_resp_last",  {31'b0, respl_tbl[0]}, 32'd1);
        setXfer(0, 1'b0, 32'h0,    32'h0, 4'h0);
        setXfer(1, 1'b0, 32'h3FFC, 32'h0, 4'h0);
        applyStimulus(2);
        checkOutput("err_word0_unchanged", rdata_tbl[0], 32'h5A5A5A5A);
        checkOutput("last_word_data", rdata_tbl[1], 32'h0BADF00D);
        checkOutput("after_err_resp", {31'b0, respl_tbl[1]}, 32'd0);

        // IDLE/BUSY transfers and a deselected write produce no data phase
        bus.HSEL = 1'b1; bus.HTRANS = 2'b00; bus.HWRITE = 1'b1; bus.HADDR = 32'h80;
        @(posedge clk); #1;
        bus.HTRANS = 2'b01;
        @(negedge clk);
        checkOutput("htrans_idle_hready", {31'b0, bus.HREADY}, 32'd1);
        checkOutput("htrans_idle_hresp",  {31'b0, bus.HRESP},  32'd0);
        @(posedge clk); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b10;
        @(negedge clk);
        checkOutput("htrans_busy_hready", {31'b0, bus.HREADY}, 32'd1);
        @(posedge clk); #1;
        driveIdle();
        bus.HWDATA = 32'hFFFFFFFF; bus.HWSTRB = 4'hF;
        @(negedge clk);
        checkOutput("hsel0_hready", {31'b0, bus.HREADY}, 32'd1);
        checkOutput("hsel0_hresp",  {31'b0, bus.HRESP},  32'd0);
        @(posedge clk); #1;
        driveIdle();
        setXfer(0, 1'b0, 32'h80, 32'h0, 4'h0);
        applyStimulus(1);
        checkOutput("no_xfer_mem_unchanged", rdata_tbl[0], 32'h11BB33DD);

        // Reset during a pending write to 0x40
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1;
        bus.HSIZE = 3'b010; bus.HADDR = 32'h40;
        @(posedge clk); #1;
        driveIdle();
        bus.HWDATA = 32'h12345678; bus.HWSTRB = 4'hF;
        #2;
        nRST = 1'b0;
        #1;
        checkOutput("rst_mid_hready", {31'b0, bus.HREADY}, 32'd1);
        checkOutput("rst_mid_hresp",  {31'b0, bus.HRESP},  32'd0);
        checkOutput("rst_mid_hrdata", bus.HRDATA, 32'h0);
        @(posedge clk);
        @(negedge clk);
        nRST = 1'b1;
        driveIdle();
        @(posedge clk); #1;
        setXfer(0, 1'b0, 32'h40, 32'h0, 4'h0);
        applyStimulus(1);
        checkOutput("rst_mid_not_committed", rdata_tbl[0], 32'hCAFEBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
